// File: rtl/period_meter_pkg.sv
// ---------------------------------------------------------------------------
// period_meter_pkg
//   Shared types and default parameters for the period meter.
//   - state_t      : measurement FSM states
//   - DEF_*        : default parameter values used by period_meter
//   - out_shift()  : left shift that turns the window sum into INT.FRAC
// ---------------------------------------------------------------------------
package period_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_TIMEOUT
  } state_t;

  localparam int DEF_PERIOD_INT_PART  = 10;
  localparam int DEF_PERIOD_FRAC_PART = 20;
  localparam int DEF_AVG_SHIFT        = 4;
  localparam int DEF_SYNC_STAGES      = 2;

  // The window sum already carries AVG_SHIFT fractional bits (it is the
  // average scaled by 2^AVG_SHIFT), so only the remainder is shifted in.
  function automatic int out_shift(input int frac_part, input int avg_shift);
    return frac_part - avg_shift;
  endfunction

endpackage

// File: rtl/period_window_sum.sv
// ---------------------------------------------------------------------------
// period_window_sum
//   Sliding-window running sum over the last 2^DEPTH_LOG2 period samples.
//   Circular history buffer + write pointer + running sum.
// Ports
//   CLK        in   clock
//   RESET      in   synchronous active-high reset (pointer and sum to 0)
//   sample     in   SAMPLE_W  period sample to insert
//   sample_en  in   1         insert sample this cycle (already CE-qualified)
//   fill_mode  in   1         window not yet full: evicted value treated as 0
//   clear      in   1         restart the window: sum <= 0, pointer <= 0
//   sum        out  SAMPLE_W+DEPTH_LOG2  running sum of the window
// ---------------------------------------------------------------------------
module period_window_sum
  import period_meter_pkg::*;
#(
  parameter int SAMPLE_W   = DEF_PERIOD_INT_PART,
  parameter int DEPTH_LOG2 = DEF_AVG_SHIFT
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic [SAMPLE_W-1:0]            sample,
  input  logic                           sample_en,
  input  logic                           fill_mode,
  input  logic                           clear,
  output logic [SAMPLE_W+DEPTH_LOG2-1:0] sum
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int SUM_W = SAMPLE_W + DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  logic [SAMPLE_W-1:0]   hist_mem [DEPTH];
  logic [SAMPLE_W-1:0]   old_rd_reg;
  logic [DEPTH_LOG2-1:0] wr_ptr_reg, wr_ptr_next;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic [SUM_W-1:0]      sum_reg, sum_next;
  logic [SUM_W-1:0]      old_val;

  // While filling, the slot being written holds stale data from an earlier
  // window, so nothing is subtracted. This is why the buffer never needs
  // clearing.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    sum_next    = sum_reg;
    old_val     = fill_mode ? '0 : SUM_W'(old_rd_reg);
    if (clear) begin
      wr_ptr_next = '0;
      sum_next    = '0;
    end else if (sample_en) begin
      wr_ptr_next = wr_ptr_reg + PTR_ONE;
      sum_next    = sum_reg + SUM_W'(sample) - old_val;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_reg <= '0;
      sum_reg    <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      sum_reg    <= sum_next;
    end
  end

  // Registered read prefetches the slot the *next* write will evict, so
  // old_rd_reg always equals hist_mem[wr_ptr_reg]. A write goes to
  // wr_ptr_reg while the read targets wr_ptr_reg+1, so they never collide.
  assign rd_addr = RESET ? '0 : wr_ptr_next;

  always_ff @(posedge CLK) begin
    if (sample_en && !clear && !RESET) begin
      hist_mem[wr_ptr_reg] <= sample;
    end
    old_rd_reg <= hist_mem[rd_addr];
  end

  assign sum = sum_reg;

endmodule

// File: rtl/period_meter.sv
// ---------------------------------------------------------------------------
// period_meter
//   Measures the period of an asynchronous square wave in CE-qualified CLK
//   cycles and averages it over a sliding window of 2^AVG_SHIFT periods.
//   PERIOD_OUT is INT.FRAC fixed point, ready for smooth_oscillator.PERIOD_IN.
// Ports
//   CLK           in   sole clock
//   RESET         in   synchronous, active-high
//   CE            in   clock enable; everything except the synchronizer frozen
//   SIGNAL_IN     in   asynchronous sensor square wave
//   PERIOD_OUT    out  INT+FRAC  averaged period (INT.FRAC)
//   PERIOD_VALID  out  1-cycle strobe when PERIOD_OUT updates (0 when CE=0)
//   TIMEOUT       out  level; no rising edge for 2^INT-1 CE cycles
// ---------------------------------------------------------------------------
module period_meter
  import period_meter_pkg::*;
#(
  parameter int PERIOD_INT_PART  = DEF_PERIOD_INT_PART,
  parameter int PERIOD_FRAC_PART = DEF_PERIOD_FRAC_PART,
  parameter int AVG_SHIFT        = DEF_AVG_SHIFT,
  parameter int SYNC_STAGES      = DEF_SYNC_STAGES
) (
  input  logic                                      CLK,
  input  logic                                      RESET,
  input  logic                                      CE,
  input  logic                                      SIGNAL_IN,
  output logic [PERIOD_INT_PART+PERIOD_FRAC_PART-1:0] PERIOD_OUT,
  output logic                                      PERIOD_VALID,
  output logic                                      TIMEOUT
);

  localparam int INT_W   = PERIOD_INT_PART;
  localparam int SUM_W   = PERIOD_INT_PART + AVG_SHIFT;
  localparam int OUT_W   = PERIOD_INT_PART + PERIOD_FRAC_PART;
  localparam int OUT_LSH = out_shift(PERIOD_FRAC_PART, AVG_SHIFT);

  localparam logic [INT_W-1:0]     CNT_MAX   = '1;
  localparam logic [INT_W-1:0]     CNT_ONE   = INT_W'(1);
  localparam logic [AVG_SHIFT-1:0] FILL_LAST = '1;
  localparam logic [AVG_SHIFT-1:0] FILL_ONE  = AVG_SHIFT'(1);

  // ---------------- synchronizer (free-running, ignores CE) ----------------
  logic [SYNC_STAGES-1:0] sync_reg, sync_next;
  logic                   sync_out;

  assign sync_next[0] = SIGNAL_IN;
  generate
    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
      assign sync_next[gi] = sync_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RESET) sync_reg <= '0;
    else       sync_reg <= sync_next;
  end

  assign sync_out = sync_reg[SYNC_STAGES-1];

  // ---------------- edge detect and period counter ----------------
  // prev only advances on CE cycles, so a rise seen while CE=0 is still
  // reported on the next CE cycle.
  logic             prev_reg, prev_next;
  logic             edge_det;
  logic [INT_W-1:0] cnt_reg, cnt_next;
  logic             cnt_at_max;
  logic             go_timeout;

  assign edge_det   = CE & sync_out & ~prev_reg;
  assign cnt_at_max = (cnt_reg == CNT_MAX);

  always_comb begin
    prev_next = prev_reg;
    cnt_next  = cnt_reg;
    if (CE) begin
      prev_next = sync_out;
      if (edge_det)         cnt_next = CNT_ONE;
      else if (!cnt_at_max) cnt_next = cnt_reg + CNT_ONE;
    end
  end

  // Timeout state is entered on the same clock that cnt saturates, so
  // TIMEOUT rises exactly MAX CE cycles after the last edge.
  assign go_timeout = CE & ~edge_det & (cnt_next == CNT_MAX);

  // ---------------- FSM ----------------
  state_t               state_reg, state_next;
  logic [AVG_SHIFT-1:0] fill_reg, fill_next;
  logic                 vpipe_reg, vpipe_next;
  logic                 win_sample_en, win_clear, restart;
  logic [SUM_W-1:0]     win_sum;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= ST_IDLE;
      fill_reg  <= '0;
      vpipe_reg <= 1'b0;
      cnt_reg   <= '0;
      prev_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      fill_reg  <= fill_next;
      vpipe_reg <= vpipe_next;
      cnt_reg   <= cnt_next;
      prev_reg  <= prev_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    fill_next     = fill_reg;
    win_sample_en = 1'b0;
    win_clear     = 1'b0;
    vpipe_next    = CE ? 1'b0 : vpipe_reg;
    // An edge with a saturated counter carries no valid period: it only
    // re-arms the window as a reference edge.
    restart       = edge_det & (cnt_at_max || state_reg == ST_IDLE ||
                                state_reg == ST_TIMEOUT);
    if (restart) begin
      state_next = ST_FILL;
      fill_next  = '0;
      win_clear  = 1'b1;
    end else if (edge_det) begin
      case (state_reg)
        ST_FILL: begin
          win_sample_en = 1'b1;
          fill_next     = fill_reg + FILL_ONE;
          if (fill_reg == FILL_LAST) begin
            state_next = ST_RUN;
            vpipe_next = 1'b1;
          end
        end
        ST_RUN: begin
          win_sample_en = 1'b1;
          vpipe_next    = 1'b1;
        end
        default: state_next = ST_IDLE;
      endcase
    end else if (go_timeout) begin
      state_next = ST_TIMEOUT;
    end
  end

  period_window_sum #(
    .SAMPLE_W   (INT_W),
    .DEPTH_LOG2 (AVG_SHIFT)
  ) u_window (
    .CLK       (CLK),
    .RESET     (RESET),
    .sample    (cnt_reg),
    .sample_en (win_sample_en),
    .fill_mode (state_reg == ST_FILL),
    .clear     (win_clear),
    .sum       (win_sum)
  );

  // ---------------- output register ----------------
  logic [OUT_W-1:0] period_out_reg, period_out_next;
  logic             valid_reg, valid_next;

  always_comb begin
    period_out_next = period_out_reg;
    valid_next      = valid_reg;
    if (CE) begin
      valid_next = vpipe_reg;
      if (vpipe_reg) period_out_next = OUT_W'(win_sum) << OUT_LSH;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      period_out_reg <= '0;
      valid_reg      <= 1'b0;
    end else begin
      period_out_reg <= period_out_next;
      valid_reg      <= valid_next;
    end
  end

  // valid_reg can be held across CE=0 cycles; gating with CE makes the
  // strobe last exactly one enabled cycle.
  assign PERIOD_OUT   = period_out_reg;
  assign PERIOD_VALID = valid_reg & CE;
  assign TIMEOUT      = (state_reg == ST_TIMEOUT);

endmodule
